sequence_generator: RTL and testbench

- Free-running 4-bit sequence generator clocked every cycle with no enable or handshake.
- A compile-time MODE parameter selects one of four cyclic sequences: binary up-count, Gray code, Johnson (twisted ring) or maximal-length LFSR.
- Used as a pattern/stimulus source or simple state sequencer.
- The output is registered directly; there is no combinational path from any input to count.

---
 rtl/seq_gen_pkg.sv | 18 +
 rtl/seq_gen_next.sv | 54 +++++
 rtl/sequence_generator.sv | 44 ++++
 tb/tb_sequence_generator.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants and helpers for the 4-bit sequence generator.
package seq_gen_pkg;

  localparam int unsigned MODE_BIN     = 0;
  localparam int unsigned MODE_GRAY    = 1;
  localparam int unsigned MODE_JOHNSON = 2;
  localparam int unsigned MODE_LFSR    = 3;

  // Reset value per mode; the LFSR must never start in its all-zero lock-up state.
  function automatic logic [3:0] seed(input int unsigned mode);
    return (mode == MODE_LFSR) ? 4'b0001 : 4'b0000;
  endfunction

  function automatic logic [3:0] bin2gray(input logic [3:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/seq_gen_next.sv
// Combinational successor logic for every sequence mode, including recovery from illegal states.
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int unsigned MODE = 0,
  parameter int unsigned LAST = 15
) (
  input  logic [3:0] cur_count,
  input  logic [3:0] cur_idx,
  output logic [3:0] next_count,
  output logic [3:0] next_idx
);

  localparam logic [3:0] LAST4 = 4'(LAST);

  function automatic logic is_johnson(input logic [3:0] v);
    case (v)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Select the successor for the configured mode; unknown modes fall back to binary.
  always_comb begin
    next_count = '0;
    next_idx   = cur_idx;
    case (MODE)
      MODE_GRAY: begin
        next_idx   = cur_idx + 4'd1;
        next_count = bin2gray(next_idx);
      end
      MODE_JOHNSON: begin
        if (is_johnson(cur_count))
          next_count = {~cur_count[0], cur_count[3:1]};
        else
          next_count = '0;
      end
      MODE_LFSR: begin
        if (cur_count == 4'b0000)
          next_count = 4'b0001;
        else
          next_count = {cur_count[2:0], cur_count[3] ^ cur_count[2]};
      end
      default: begin
        if (cur_count < LAST4)
          next_count = cur_count + 4'd1;
        else
          next_count = '0;
      end
    endcase
  end

endmodule

// File: rtl/sequence_generator.sv
// Free-running 4-bit sequence generator: state registers with asynchronous active-low reset.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned MODE = 0,
  parameter int unsigned LAST = 15
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] count
);

  if (LAST < 1 || LAST > 15) begin : g_bad_last
    $error("sequence_generator: LAST=%0d outside legal range 1..15", LAST);
  end

  localparam logic [3:0] SEED = seed(MODE);

  logic [3:0] idx;
  logic [3:0] count_next;
  logic [3:0] idx_next;

  seq_gen_next #(
    .MODE (MODE),
    .LAST (LAST)
  ) u_next (
    .cur_count  (count),
    .cur_idx    (idx),
    .next_count (count_next),
    .next_idx   (idx_next)
  );

  // Advance one step per rising edge; reset forces the seed immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= SEED;
      idx   <= '0;
    end else begin
      count <= count_next;
      idx   <= idx_next;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench: stimulus queues expected values per cycle, a monitor checks them on the falling edge.
module tb_sequence_generator;
  import seq_gen_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] c_bin15, c_bin9, c_gray, c_john, c_lfsr;

  always #5 clk = ~clk;

  sequence_generator #(.MODE(0), .LAST(15)) u_bin15 (.clk(clk), .reset(reset), .count(c_bin15));
  sequence_generator #(.MODE(0), .LAST(9))  u_bin9  (.clk(clk), .reset(reset), .count(c_bin9));
  sequence_generator #(.MODE(1), .LAST(15)) u_gray  (.clk(clk), .reset(reset), .count(c_gray));
  sequence_generator #(.MODE(2), .LAST(15)) u_john  (.clk(clk), .reset(reset), .count(c_john));
  sequence_generator #(.MODE(3), .LAST(15)) u_lfsr  (.clk(clk), .reset(reset), .count(c_lfsr));

  // Illegal-state recovery probes on the successor logic
  logic [3:0] j_in  = 4'b0101;
  logic [3:0] l_in  = 4'b0000;
  logic [3:0] b_in  = 4'd12;
  logic [3:0] g_idx = 4'd15;
  logic [3:0] zero4 = 4'd0;
  logic [3:0] j_out, l_out, b_out, g_out, g_idx_out;

  seq_gen_next #(.MODE(2), .LAST(15)) u_jn (.cur_count(j_in), .cur_idx(zero4), .next_count(j_out), .next_idx());
  seq_gen_next #(.MODE(3), .LAST(15)) u_ln (.cur_count(l_in), .cur_idx(zero4), .next_count(l_out), .next_idx());
  seq_gen_next #(.MODE(0), .LAST(9))  u_bn (.cur_count(b_in), .cur_idx(zero4), .next_count(b_out), .next_idx());
  seq_gen_next #(.MODE(1), .LAST(15)) u_gn (.cur_count(4'b1000), .cur_idx(g_idx), .next_count(g_out), .next_idx(g_idx_out));

  localparam logic [3:0] GRAY_TAB [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  localparam logic [3:0] JOHN_TAB [8] = '{
    4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  localparam logic [3:0] LFSR_TAB [15] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
    4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  typedef struct {
    int         step;
    logic [3:0] bin15, bin9, gray, john, lfsr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;
  logic [3:0] lfsr_log [16];

  task automatic check(input string name, input int step, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    end
  endtask

  // step < 0 means the circuit is held in reset
  function automatic exp_t expected(input int step);
    exp_t e;
    e.step = step;
    if (step < 0) begin
      e.bin15 = 4'b0000; e.bin9 = 4'b0000; e.gray = 4'b0000; e.john = 4'b0000; e.lfsr = 4'b0001;
    end else begin
      e.bin15 = 4'(step % 16);
      e.bin9  = 4'(step % 10);
      e.gray  = GRAY_TAB[step % 16];
      e.john  = JOHN_TAB[step % 8];
      e.lfsr  = LFSR_TAB[step % 15];
    end
    return e;
  endfunction

  // Monitor: compare every queued expectation on the falling edge
  initial begin
    exp_t e;
    int prev_step = -10;
    logic [3:0] prev_gray = '0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("bin15", e.step, c_bin15, e.bin15);
        check("bin9",  e.step, c_bin9,  e.bin9);
        check("gray",  e.step, c_gray,  e.gray);
        check("johnson", e.step, c_john, e.john);
        check("lfsr",  e.step, c_lfsr,  e.lfsr);
        if (e.step >= 1 && prev_step == e.step - 1)
          check("gray_hamming", e.step, 4'($countones(prev_gray ^ c_gray)), 4'd1);
        if (e.step >= 1 && e.step <= 15)
          lfsr_log[e.step] = c_lfsr;
        prev_step = e.step;
        prev_gray = c_gray;
      end
    end
  end

  task automatic run_from_release(input int n);
    @(posedge clk);
    #2 reset = 1'b1;
    sb.push_back(expected(0));
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      sb.push_back(expected(k));
    end
  endtask

  // Stimulus: reset, long run, async reset mid-sequence, restart, then recovery probes
  initial begin
    logic [15:0] seen;
    int dups;
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      sb.push_back(expected(-1));
    end
    run_from_release(41);

    // every mode is away from its seed at step 41
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_bin15", -2, c_bin15, 4'b0000);
    check("async_bin9",  -2, c_bin9,  4'b0000);
    check("async_gray",  -2, c_gray,  4'b0000);
    check("async_john",  -2, c_john,  4'b0000);
    check("async_lfsr",  -2, c_lfsr,  4'b0001);
    @(posedge clk);
    sb.push_back(expected(-1));
    run_from_release(20);

    @(negedge clk);
    #1;
    check("queue_drained", -3, 4'(sb.size()), 4'd0);

    seen = '0;
    dups = 0;
    for (int i = 1; i <= 15; i++) begin
      if (seen[lfsr_log[i]]) dups++;
      seen[lfsr_log[i]] = 1'b1;
    end
    check("lfsr_distinct", 15, 4'($countones(seen[15:1])), 4'd15);
    check("lfsr_dups", 15, 4'(dups), 4'd0);

    check("john_recover_0101", -4, j_out, 4'b0000);
    check("lfsr_recover_0000", -4, l_out, 4'b0001);
    check("bin9_recover_12",   -4, b_out, 4'b0000);
    check("gray_wrap_count",   -4, g_out, 4'b0000);
    check("gray_wrap_idx",     -4, g_idx_out, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
